// File: rtl/cdb_wb_arbiter.sv
// Purpose: buffers one result per functional unit and arbitrates them onto a single writeback (CDB) slot.
// Latency: 1 cycle minimum from req handshake to wb_valid; no combinational path from req_* to wb_*.
// Backpressure: wb_ready low holds the selected entry stable; req_ready[i] stays low while buffer i is occupied.
module cdb_wb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int MAX_WAIT      = 8,
  localparam int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ-1:0][4:0]                 req_rd_addr,
  input  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]   req_rob_idx,
  output logic                                    wb_valid,
  input  logic                                    wb_ready,
  output logic [DATA_WIDTH-1:0]                   wb_data,
  output logic [4:0]                              wb_rd_addr,
  output logic [ROB_IDX_WIDTH-1:0]                wb_rob_idx,
  output logic [SRC_W-1:0]                        wb_src
);

  localparam logic [3:0]       WAIT_TH  = 4'(MAX_WAIT);
  localparam logic [3:0]       WAIT_MAX = 4'hF;
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  // Per-requester result buffer
  logic [NUM_REQ-1:0]                     full;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     buf_data;
  logic [NUM_REQ-1:0][4:0]                buf_rd;
  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]  buf_rob;
  logic [NUM_REQ-1:0][3:0]                wait_cnt;

  // Arbitration state: round-robin pointer and the index held across a stall
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] hold_idx;
  logic             hold_vld;

  logic [SRC_W-1:0]   rr_idx;
  logic               rr_vld;
  logic [SRC_W-1:0]   ovr_idx;
  logic               ovr_vld;
  logic [SRC_W-1:0]   sel;
  logic               grant;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [NUM_REQ-1:0] load;

  // Round-robin scan: first full buffer at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j      = 0;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!rr_vld && full[j]) begin
        rr_vld = 1'b1;
        rr_idx = SRC_W'(j);
      end
    end
  end

  // Starvation override: lowest-index full buffer whose wait reached the threshold
  always_comb begin
    ovr_vld = 1'b0;
    ovr_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (full[i] && (wait_cnt[i] >= WAIT_TH)) begin
        ovr_vld = 1'b1;
        ovr_idx = SRC_W'(i);
      end
    end
  end

  // Final selection: override first, then the entry held through a stall, then round-robin
  always_comb begin
    sel = rr_idx;
    if (ovr_vld) begin
      sel = ovr_idx;
    end else if (hold_vld && full[hold_idx]) begin
      sel = hold_idx;
    end
  end

  // Writeback outputs, forced to zero when the slot is idle or flushing
  always_comb begin
    wb_valid   = rr_vld && !flush;
    wb_src     = '0;
    wb_data    = '0;
    wb_rd_addr = '0;
    wb_rob_idx = '0;
    if (wb_valid) begin
      wb_src     = sel;
      wb_data    = buf_data[sel];
      wb_rd_addr = buf_rd[sel];
      wb_rob_idx = buf_rob[sel];
    end
  end

  // Grant decode and request acceptance; a granted buffer may be refilled in the same cycle
  always_comb begin
    grant     = wb_valid && wb_ready;
    gnt_vec   = '0;
    req_ready = '0;
    load      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_vec[i]   = grant && (sel == SRC_W'(i));
      req_ready[i] = !flush && (!full[i] || gnt_vec[i]);
      load[i]      = req_valid[i] && req_ready[i];
    end
  end

  // Buffer contents and wait counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wait_cnt <= '0;
      buf_data <= '0;
      buf_rd   <= '0;
      buf_rob  <= '0;
    end else if (flush) begin
      full     <= '0;
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          full[i]     <= 1'b1;
          buf_data[i] <= req_data[i];
          buf_rd[i]   <= req_rd_addr[i];
          buf_rob[i]  <= req_rob_idx[i];
          wait_cnt[i] <= '0;
        end else if (gnt_vec[i]) begin
          full[i]     <= 1'b0;
          wait_cnt[i] <= '0;
        end else if (full[i]) begin
          if (wait_cnt[i] != WAIT_MAX) begin
            wait_cnt[i] <= wait_cnt[i] + 4'd1;
          end
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  // Round-robin pointer advances past the winner; stall hold remembers the current choice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      hold_vld <= 1'b0;
      hold_idx <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= (sel == LAST_IDX) ? '0 : sel + SRC_W'(1);
      end
      hold_vld <= wb_valid && !wb_ready;
      hold_idx <= sel;
    end
  end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Purpose: directed self-checking bench for cdb_wb_arbiter (4 requesters, MAX_WAIT=3).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: wb_ready driven per scenario to exercise stalls and holds.
module tb_cdb_wb_arbiter;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_data;
  logic [3:0][4:0]  req_rd_addr;
  logic [3:0][4:0]  req_rob_idx;
  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_data;
  logic [4:0]       wb_rd_addr;
  logic [4:0]       wb_rob_idx;
  logic [1:0]       wb_src;

  int n_vec;
  int n_err;

  cdb_wb_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .ROB_IDX_WIDTH(5), .MAX_WAIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_rd_addr(req_rd_addr), .req_rob_idx(req_rob_idx),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd_addr(wb_rd_addr), .wb_rob_idx(wb_rob_idx), .wb_src(wb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Sample at negedge and compare the writeback slot
  task automatic exp_wb(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(wb_valid), 64'(v));
    chk({tag, "_src"},   64'(wb_src),   64'(s));
    chk({tag, "_data"},  64'(wb_data),  64'(d));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    req_valid   = '0;
    wb_ready    = 1'b0;
    req_data    = '0;
    req_rd_addr = '0;
    req_rob_idx = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(wb_valid), 64'h0);
    chk("rst_data",  64'(wb_data),  64'h0);
    chk("rst_src",   64'(wb_src),   64'h0);
    chk("rst_rdy",   64'(req_ready), 64'hF);
    nxt();
    rst_n = 1'b1;

    // Single request on FU 1: visible one cycle later, then slot idles
    req_valid      = 4'b0010;
    req_data[1]    = 32'hDEAD_BEEF;
    req_rob_idx[1] = 5'd3;
    req_rd_addr[1] = 5'd7;
    wb_ready       = 1'b1;
    exp_wb("single_nocomb", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid = '0;
    exp_wb("single", 1'b1, 2'd1, 32'hDEAD_BEEF);
    chk("single_rob", 64'(wb_rob_idx), 64'd3);
    chk("single_rd",  64'(wb_rd_addr), 64'd7);
    nxt();
    exp_wb("single_idle", 1'b0, 2'd0, 32'h0);
    nxt();

    // Round-robin from a fresh reset; late request on 0 waits behind 2 and 3
    pulse_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = 32'h100 + 32'(i);
    exp_wb("rr_load", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid = '0;
    exp_wb("rr0", 1'b1, 2'd0, 32'h100);
    nxt();
    req_valid   = 4'b0001;
    req_data[0] = 32'h200;
    exp_wb("rr1", 1'b1, 2'd1, 32'h101);
    chk("rr1_rdy0", 64'(req_ready[0]), 64'h1);
    nxt();
    req_valid = '0;
    exp_wb("rr2", 1'b1, 2'd2, 32'h102);
    nxt();
    exp_wb("rr3", 1'b1, 2'd3, 32'h103);
    nxt();
    exp_wb("rr4", 1'b1, 2'd0, 32'h200);
    nxt();
    exp_wb("rr_idle", 1'b0, 2'd0, 32'h0);
    nxt();

    // Backpressure on buffer 2 with a pending refill held off
    req_valid   = 4'b0100;
    req_data[2] = 32'h300;
    wb_ready    = 1'b0;
    exp_wb("bp_load", 1'b0, 2'd0, 32'h0);
    nxt();
    req_data[2] = 32'h301;
    for (int k = 0; k < 5; k++) begin
      exp_wb("bp_hold", 1'b1, 2'd2, 32'h300);
      chk("bp_rdy2", 64'(req_ready[2]), 64'h0);
      nxt();
    end
    wb_ready = 1'b1;
    exp_wb("bp_go", 1'b1, 2'd2, 32'h300);
    chk("bp_rdy2_go", 64'(req_ready[2]), 64'h1);
    nxt();
    req_valid = '0;
    exp_wb("bp_reload", 1'b1, 2'd2, 32'h301);
    nxt();
    exp_wb("bp_idle", 1'b0, 2'd0, 32'h0);
    nxt();

    // Stall with 3 selected; once 1 also crosses the threshold the lower index wins
    wb_ready    = 1'b0;
    req_valid   = 4'b1000;
    req_data[3] = 32'h400;
    exp_wb("ov_a", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid   = 4'b0010;
    req_data[1] = 32'h410;
    exp_wb("ov_b", 1'b1, 2'd3, 32'h400);
    nxt();
    req_valid = '0;
    exp_wb("ov_c", 1'b1, 2'd3, 32'h400);
    nxt();
    exp_wb("ov_d", 1'b1, 2'd3, 32'h400);
    nxt();
    exp_wb("ov_e", 1'b1, 2'd3, 32'h400);
    nxt();
    wb_ready = 1'b1;
    exp_wb("ov_low", 1'b1, 2'd1, 32'h410);
    nxt();
    exp_wb("ov_g", 1'b1, 2'd3, 32'h400);
    nxt();
    exp_wb("ov_idle", 1'b0, 2'd0, 32'h0);
    nxt();

    // Starvation: 0..2 keep refilling, 3 must win by the 4th cycle after load
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i] = 32'h500 + 32'(i);
    exp_wb("sv_load", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) req_data[i] = 32'h510 + 32'(i);
    exp_wb("sv1", 1'b1, 2'd0, 32'h500);
    nxt();
    exp_wb("sv2", 1'b1, 2'd1, 32'h501);
    nxt();
    exp_wb("sv3", 1'b1, 2'd2, 32'h502);
    nxt();
    req_valid = '0;
    exp_wb("sv4", 1'b1, 2'd3, 32'h503);
    nxt();
    exp_wb("sv5", 1'b1, 2'd0, 32'h510);
    nxt();
    exp_wb("sv6", 1'b1, 2'd1, 32'h511);
    nxt();
    exp_wb("sv7", 1'b1, 2'd2, 32'h512);
    nxt();
    exp_wb("sv_idle", 1'b0, 2'd0, 32'h0);
    nxt();

    // Flush with buffers 0 and 2 full; rr_ptr (=1) must survive it
    pulse_reset();
    req_valid   = 4'b0001;
    req_data[0] = 32'h600;
    exp_wb("fl_a", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid   = 4'b0101;
    req_data[0] = 32'h610;
    req_data[2] = 32'h620;
    exp_wb("fl_b", 1'b1, 2'd0, 32'h600);
    nxt();
    flush     = 1'b1;
    req_valid = 4'b0010;
    exp_wb("fl_during", 1'b0, 2'd0, 32'h0);
    chk("fl_rdy_during", 64'(req_ready), 64'h0);
    nxt();
    flush     = 1'b0;
    req_valid = '0;
    exp_wb("fl_after", 1'b0, 2'd0, 32'h0);
    chk("fl_rdy_after", 64'(req_ready), 64'hF);
    nxt();
    req_valid   = 4'b1001;
    req_data[0] = 32'h630;
    req_data[3] = 32'h633;
    exp_wb("fl_reload", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid = '0;
    exp_wb("fl_rr", 1'b1, 2'd3, 32'h633);
    nxt();
    exp_wb("fl_rr2", 1'b1, 2'd0, 32'h630);
    nxt();
    exp_wb("fl_idle", 1'b0, 2'd0, 32'h0);
    nxt();

    // Reset mid-cycle with three buffers full
    wb_ready  = 1'b0;
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) req_data[i] = 32'h700 + 32'(i);
    exp_wb("rs_load", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid = '0;
    exp_wb("rs_full", 1'b1, 2'd1, 32'h701);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_valid_imm", 64'(wb_valid), 64'h0);
    chk("rs_src_imm",   64'(wb_src),   64'h0);
    chk("rs_rdy_imm",   64'(req_ready), 64'hF);
    nxt();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    exp_wb("rs_idle1", 1'b0, 2'd0, 32'h0);
    nxt();
    exp_wb("rs_idle2", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid   = 4'b0101;
    req_data[0] = 32'h710;
    req_data[2] = 32'h712;
    exp_wb("rs_new", 1'b0, 2'd0, 32'h0);
    nxt();
    req_valid = '0;
    exp_wb("rs_g0", 1'b1, 2'd0, 32'h710);
    nxt();
    exp_wb("rs_g2", 1'b1, 2'd2, 32'h712);
    nxt();
    exp_wb("rs_end", 1'b0, 2'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_wb_arbiter.md
CDB_WB_ARBITER -- requirements
Module: cdb_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of functional-unit requesters (0=alu,1=mul,2=br,3=mem).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result width.
REQ-003 SHALL have parameter ROB_IDX_WIDTH, default 5, ROB tag width.
REQ-004 SHALL have parameter MAX_WAIT, default 8, starvation threshold in cycles (2..15).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port flush  input  1  pipeline flush (mispredict), synchronous.
REQ-008 SHALL have port req_valid  input  NUM_REQ  per-FU result valid.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-FU buffer can accept.
REQ-010 SHALL have port req_data  input  NUM_REQ x DATA_WIDTH  per-FU result.
REQ-011 SHALL have port req_rd_addr  input  NUM_REQ x 5  per-FU destination arch reg.
REQ-012 SHALL have port req_rob_idx  input  NUM_REQ x ROB_IDX_WIDTH  per-FU ROB tag.
REQ-013 SHALL have port wb_valid  output  1  shared writeback (CDB) slot valid.
REQ-014 SHALL have port wb_ready  input  1  ROB/regfile accepts writeback.
REQ-015 SHALL have port wb_data, wb_rd_addr, wb_rob_idx  output  DATA_WIDTH/5/ROB_IDX_WIDTH  granted result fields.
REQ-016 SHALL have port wb_src  output  clog2(NUM_REQ)  index of granted requester.

Function
REQ-017 SHALL hold one buffer entry (full flag, data, rd_addr, rob_idx, 4-bit wait counter) per requester.
REQ-018 req_ready[i] SHALL be 1 when buffer i empty, or full and granted this cycle; 0 during flush.
REQ-019 Handshake req_valid[i] && req_ready[i] at edge N SHALL load buffer i; entry earliest visible on wb at cycle N+1 (1-cycle min latency, no combinational req->wb path).
REQ-020 Grant SHALL occur when wb_valid && wb_ready; granted buffer empties, or reloads if same-cycle handshake on that requester.
REQ-021 wb_valid SHALL be 1 iff any buffer full and flush==0; wb_* fields combinationally from selected buffer; fields 0 when wb_valid==0.
REQ-022 Selection SHALL be round-robin: first full buffer scanning from rr_ptr upward modulo NUM_REQ.
REQ-023 rr_ptr SHALL update to (granted index + 1) mod NUM_REQ on a grant only; wraps NUM_REQ-1 -> 0.
REQ-024 Wait counter i SHALL increment (saturating at 15) each cycle buffer i full and not granted; clear on grant, load, or empty.
REQ-025 Any buffer with wait counter >= MAX_WAIT SHALL override round-robin; among several, lowest index wins.
REQ-026 While wb_ready==0 selection SHALL remain stable (same wb_src/fields) unless an override per REQ-025 newly triggers.
REQ-027 flush==1 SHALL clear all full flags and wait counters at that edge, ignore same-cycle requests, and produce no grant; rr_ptr unchanged.
REQ-028 Simultaneous requests to all empty buffers SHALL all be accepted in one cycle.

Reset
REQ-029 rst_n==0 SHALL immediately clear all full flags, wait counters, rr_ptr=0; outputs: wb_valid=0, wb_*=0, wb_src=0, req_ready=all 1.
REQ-030 Reset asserted mid-transfer SHALL discard buffered results; first post-reset grant starts from index 0.
REQ-031 Release of rst_n SHALL be synchronized externally; block accepts requests the first edge after release.

Verification
REQ-032 Single: req_valid[1]=1, data 0xDEAD_BEEF, rob 3, wb_ready=1 -> next cycle wb_valid=1, wb_src=1, wb_data=0xDEADBEEF, wb_rob_idx=3; following cycle wb_valid=0.
REQ-033 Round-robin: all 4 request same cycle, wb_ready=1 -> wb_src sequence 0,1,2,3 over 4 cycles; new req on 0 at cycle 2 served after 3.
REQ-034 Backpressure: buffer 2 full, wb_ready=0 for 5 cycles -> wb_src=2 stable, req_ready[2]=0, new req_valid[2] held until grant.
REQ-035 Starvation: MAX_WAIT=3, requester 3 full while 0..2 continuously refill -> requester 3 granted no later than 4th cycle after load.
REQ-036 Flush: buffers 0,2 full, flush=1 with req_valid[1]=1 -> next cycle wb_valid=0, all req_ready=1, rr_ptr unchanged.
REQ-037 Reset: rst_n low mid-cycle with 3 buffers full -> wb_valid=0 immediately, no grants after release until new requests.
